// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Shares the register bank's single write port between the execute (A) and
// memory (B) writeback paths, and keeps per-register reservation counters
// that drive the read-after-write hazard signal seen by issue.
module regfile_write_scheduler #(
  parameter int XLEN       = 32,
  parameter int AMOUNT     = 16,
  parameter int ADDRESSLEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aValid,
  input  logic [ADDRESSLEN-1:0] aAddr,
  input  logic [XLEN-1:0]       aData,
  output logic                  aReady,
  input  logic                  bValid,
  input  logic [ADDRESSLEN-1:0] bAddr,
  input  logic [XLEN-1:0]       bData,
  output logic                  bReady,
  input  logic                  rsvValid,
  input  logic [ADDRESSLEN-1:0] rsvAddr,
  output logic                  rsvReady,
  input  logic [ADDRESSLEN-1:0] RAddress1,
  input  logic [ADDRESSLEN-1:0] RAddress2,
  output logic                  hazard,
  output logic [ADDRESSLEN-1:0] RWhich,
  output logic [XLEN-1:0]       dataWrite,
  output logic                  writeEnabled,
  output logic                  err
);

  // Round-robin pointer: 0 favours A, 1 favours B when both request.
  logic                  rr_b_q, rr_b_d;
  logic                  grant_a_s, grant_b_s, gnt_s;
  logic [ADDRESSLEN-1:0] gnt_addr_s;
  logic [XLEN-1:0]       gnt_data_s;
  logic                  rsv_acc_s;
  logic [1:0]            pend_q [AMOUNT];
  logic [1:0]            pend_d [AMOUNT];
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDRESSLEN-1:0] rwhich_q, rwhich_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  // Arbitrate the write port and select the granted address/data.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (aValid && (!bValid || !rr_b_q)) begin
      grant_a_s = 1'b1;
    end else if (bValid) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
    gnt_s      = grant_a_s | grant_b_s;
    gnt_addr_s = grant_b_s ? bAddr : aAddr;
    gnt_data_s = grant_b_s ? bData : aData;
  end

  // Next pointer, write register and sticky error state.
  always_comb begin
    rr_b_d   = rr_b_q;
    we_d     = 1'b0;
    rwhich_d = rwhich_q;
    wdata_d  = wdata_q;
    if (grant_a_s) begin
      rr_b_d = 1'b1;
    end else if (grant_b_s) begin
      rr_b_d = 1'b0;
    end else begin
      rr_b_d = rr_b_q;
    end
    if (gnt_s) begin
      we_d     = 1'b1;
      rwhich_d = gnt_addr_s;
      wdata_d  = gnt_data_s;
    end else begin
      we_d = 1'b0;
    end
    err_d = err_q | (gnt_s & (pend_q[gnt_addr_s] == 2'd0));
  end

  // A reservation is refused only on a saturated counter, unless the same
  // cycle's commit frees a slot on that register.
  always_comb begin
    rsvReady  = (pend_q[rsvAddr] != 2'd3) | (gnt_s & (gnt_addr_s == rsvAddr));
    rsv_acc_s = rsvValid & rsvReady;
  end

  // Per-register outstanding-write counters; reserve and commit cancel.
  always_comb begin
    for (int r = 0; r < AMOUNT; r++) begin
      logic inc_s, dec_s;
      inc_s = rsv_acc_s & (rsvAddr == ADDRESSLEN'(r));
      dec_s = gnt_s & (gnt_addr_s == ADDRESSLEN'(r));
      pend_d[r] = pend_q[r];
      if (inc_s && dec_s) begin
        pend_d[r] = pend_q[r];
      end else if (inc_s) begin
        pend_d[r] = pend_q[r] + 2'd1;
      end else if (dec_s && (pend_q[r] != 2'd0)) begin
        pend_d[r] = pend_q[r] - 2'd1;
      end else begin
        pend_d[r] = pend_q[r];
      end
    end
  end

  // Hazard is driven purely by the outstanding counters.
  always_comb begin
    hazard = (pend_q[RAddress1] != 2'd0) | (pend_q[RAddress2] != 2'd0);
    aReady = grant_a_s;
    bReady = grant_b_s;
  end

  // State registers; reset drops any granted-but-unregistered write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_b_q   <= 1'b0;
      we_q     <= 1'b0;
      rwhich_q <= {ADDRESSLEN{1'b0}};
      wdata_q  <= {XLEN{1'b0}};
      err_q    <= 1'b0;
      for (int r = 0; r < AMOUNT; r++) begin
        pend_q[r] <= 2'd0;
      end
    end else begin
      rr_b_q   <= rr_b_d;
      we_q     <= we_d;
      rwhich_q <= rwhich_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      for (int r = 0; r < AMOUNT; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  assign writeEnabled = we_q;
  assign RWhich       = rwhich_q;
  assign dataWrite    = wdata_q;
  assign err          = err_q;

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the register file's single write port between two writeback sources: execute-stage results (port A) and memory/load results (port B). It also tracks outstanding destination-register reservations to produce a read-after-write hazard signal for issue. It sits between the pipeline writeback paths and the register bank, and drives the bank's `RWhich`/`dataWrite`/`writeEnabled` inputs from registers.

## Interface

Parameters:
- `XLEN`, 32, data width.
- `AMOUNT`, 16, number of architectural registers.
- `ADDRESSLEN`, 4, register address width; log2(`AMOUNT`).

Ports:
- `clk` input 1: single clock, all state on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `aValid` input 1: port A write request.
- `aAddr` input ADDRESSLEN: port A destination.
- `aData` input XLEN: port A data.
- `aReady` output 1: port A grant; a transfer occurs when `aValid` and `aReady` are both high.
- `bValid`, `bAddr`, `bData`, `bReady`: port B, same meanings as port A.
- `rsvValid` input 1: issue stage reserves a destination.
- `rsvAddr` input ADDRESSLEN: register being reserved.
- `rsvReady` output 1: reservation accepted.
- `RAddress1`, `RAddress2` input ADDRESSLEN: read addresses being issued, for hazard check.
- `hazard` output 1: a read address has an outstanding write.
- `RWhich` output ADDRESSLEN: write address to the bank, registered.
- `dataWrite` output XLEN: write data to the bank, registered.
- `writeEnabled` output 1: write strobe to the bank, registered.
- `err` output 1: sticky; a write was committed to a register with no reservation.

## Operation

- **Arbitration**
  - One write per cycle.
  - Only one port valid: that port is granted.
  - Both valid: round-robin. Pointer `rrB` (reset 0 = favour A). Grant goes to A when `!rrB`, otherwise to B.
  - After a grant, `rrB` points to the other port. `rrB` is unchanged when there is no grant.
  - `aReady`/`bReady` are combinational from the valids and `rrB`. They are never high together, and never high for a port whose valid is low.
  - Requesters hold valid, address and data stable until granted.
- **Write register**
  - On the posedge ending a cycle with a grant: `writeEnabled`<=1, `RWhich`<=granted addr, `dataWrite`<=granted data.
  - With no grant: `writeEnabled`<=0, and `RWhich`/`dataWrite` hold.
- **Scoreboard**
  - One 2-bit counter `pend[r]` per register.
  - An accepted reservation (`rsvValid & rsvReady`) increments `pend[rsvAddr]`.
  - A grant decrements `pend[granted addr]`.
  - Both events on the same register in the same cycle: counter unchanged.
  - `rsvReady` = `pend[rsvAddr] != 3`, or a grant to `rsvAddr` in the same cycle.
  - Grant to a register with `pend==0`: counter stays 0, and `err` is set (sticky until reset).
- **Hazard**
  - Combinational: `hazard = (pend[RAddress1]!=0) | (pend[RAddress2]!=0)`.
  - Counters are the only source; in-flight register contents are not consulted.
- **Reset** (async, `rst_n` low):
  - `writeEnabled`=0, `RWhich`=0, `dataWrite`=0.
  - `rrB`=0, all `pend`=0, `err`=0.
  - Takes effect immediately, including mid-burst. Granted-but-not-yet-registered writes are dropped.
  - After release, `aReady`/`bReady`/`rsvReady` reflect the inputs combinationally.

## Timing

- Grant in cycle N (`aReady&aValid` sampled at posedge ending N):
  - `writeEnabled` is high during cycle N+1.
  - The bank writes at the negedge inside N+1.
  - A bank read registered at the posedge ending N+1 returns the new value.
- `pend` decrements at the same posedge that sets `writeEnabled`. `hazard` for that register drops during N+1.
  - Issue presenting the address during N+1 is sampled at the posedge ending N+1, so it reads correct data.
- Sustained throughput: 1 write/cycle. With both ports continuously valid, grants alternate A,B,A,B.
- Worst-case wait for a valid port: 1 cycle.
- Reservation → hazard visible: 1 cycle (counter updates at posedge).

## Test plan

- **Reset:** assert `rst_n`=0 mid-cycle with `writeEnabled`=1 → outputs go to 0 immediately without a clock edge. After release, `hazard`=0 and `err`=0.
- **Single port:** reserve r5; next cycle `aValid`, `aAddr`=5, `aData`=0xDEADBEEF.
  - `aReady`=1 the same cycle.
  - Next cycle: `writeEnabled`=1, `RWhich`=5, `dataWrite`=0xDEADBEEF.
  - `hazard` with `RAddress1`=5 is 1 before the grant and 0 after.
- **Contention:** A and B both valid for 4 cycles (addresses 1/2, each reserved 2×) → grant order A,B,A,B. `writeEnabled` high 4 consecutive cycles. `RWhich` 1,2,1,2. Final `pend[1]`=`pend[2]`=0.
- **Saturation:** reserve r3 three times → `rsvReady`=0 on the fourth attempt. Fourth attempt coincident with a grant to r3 → `rsvReady`=1 and `pend[3]` stays 3.
- **Error:** grant a write to r7 with `pend[7]`=0 → `err`=1 from the next cycle, staying 1 through later legal writes until `rst_n` low.
- **Same-cycle reserve+commit:** `pend[9]`=1; reserve r9 and grant r9 in the same cycle → `pend[9]` stays 1 and `hazard` stays 1 for `RAddress2`=9.
